four_bit_shift_add_multiplier: RTL and testbench
================================================

# four_bit_shift_add_multiplier

Sequential 4x4 unsigned multiplier built around the 4-bit ripple-carry adder. It sits directly upstream of the adder: it latches operands, drives the adder's a/b/cin each cycle, consumes sum/cout, and shifts the partial product. A start/busy/done handshake delivers an 8-bit product after a fixed number of cycles.

## Interface
- No parameters. Operand width is fixed at 4 by the adder sub-module.

- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- multiplicand  input  4  operand M, captured when start is accepted
- multiplier  input  4  operand Q, captured when start is accepted
- busy  output  1  high while a multiplication is in progress (CALC)
- done  output  1  one-cycle pulse; product valid
- product  output  8  result; holds until next accepted start

## Operation
- Reset (synchronous, active-high): state=IDLE, busy=0, done=0, product=8'h00, internal A/C/Q/M/count = 0.
- Working registers: M[3:0], A[3:0] (upper partial product), C (carry), Q[3:0] (multiplier / lower partial product), count[1:0].
- States:
  - IDLE: if start=1, load M=multiplicand, Q=multiplier, A=0, C=0, count=0, go to CALC. Otherwise stay.
  - CALC: adder inputs a=A, b=(Q[0] ? M : 4'h0), cin=0. Next {C,A,Q} = {cout, sum, Q} >> 1, i.e. A={cout,sum[3:1]} and Q={sum[0],Q[3:1]}. count increments. When count==3, go to DONE.
  - DONE: product={A,Q}, done=1 for this cycle only, then go to IDLE.
- start outside IDLE (CALC or DONE) is ignored. It is not queued.
- Operands are captured once. Changes on multiplicand/multiplier after acceptance have no effect.
- Arithmetic: unsigned. The max result is 15x15=225 (8'hE1), so the product never overflows 8 bits. Carry out of each add is preserved via C in the shift.
- Reset mid-operation aborts immediately. No done pulse, product=0.

## Timing
- Start accepted at edge E0 (IDLE, start=1).
- busy=1 during cycles E0+1..E0+4 (four CALC cycles).
- DONE is cycle E0+5: done=1, product valid from this cycle onward.
- Back at IDLE at E0+6. The earliest next acceptance is a start sampled at edge E0+6.
- Latency start-to-done: 5 cycles. Throughput: one result per 6 cycles.
- busy and done are never high together. done is registered (state-decoded from a register, with no combinational path from start).

## Configuration
- MULT_ZERO_BYPASS_EN defined: in IDLE, if start=1 and (multiplicand==0 or multiplier==0), skip CALC and go directly to DONE with product=0. Latency is 1 cycle (done at E0+1), and busy stays 0.
- Undefined: zero operands take the normal 4-cycle CALC path. Latency is 5 cycles, with product=0.

## Structure
- Shared package: state encoding (IDLE=2'd0, CALC=2'd1, DONE=2'd2), the operand width constant (4), the product width constant (8), and the iteration count constant (4).
- One sub-module: four_bit_full_adder_module, instantiated once as the add datapath, with cin tied to 0. The FSM, registers and shifter stay in this block.

## Test plan
- Reset, then start with M=4'd3, Q=4'd5. Required: done at E0+5, product=8'd15, busy=1 for exactly 4 cycles.
- M=4'd15, Q=4'd15. Required: product=8'hE1. This checks carry propagation through C on every iteration.
- M=4'd0, Q=4'd9. Without the macro: done at E0+5, product=0. With MULT_ZERO_BYPASS_EN: done at E0+1, product=0, busy never asserted.
- Start M=4'd7, Q=4'd2, then hold start=1 with M=4'd9, Q=4'd9 throughout CALC/DONE. Required: first product=8'd14. The second request is accepted at E0+6 and yields 8'd81 at E0+11.
- Start M=4'd6, Q=4'd6, then assert reset at E0+2. Required: next cycle state=IDLE, busy=0, done=0, product=0, with no done pulse afterwards.
- Sweep all 256 operand pairs back-to-back. Required: each product equals M*Q, and exactly one done pulse is seen per accepted start.

Source files
------------

// File: rtl/four_bit_shift_add_multiplier_pkg.sv
// Shared constants and state encoding for the sequential shift-add multiplier.
package four_bit_shift_add_multiplier_pkg;

  localparam int OPERAND_W  = 4;
  localparam int PRODUCT_W  = 8;
  localparam int ITERATIONS = 4;
  localparam int COUNT_W    = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [COUNT_W-1:0] LAST_COUNT = COUNT_W'(ITERATIONS - 1);

endpackage

// File: rtl/four_bit_shift_add_multiplier_adder.sv
// 4-bit ripple-carry adder used as the add datapath of the shift-add multiplier.
module four_bit_full_adder_module
  import four_bit_shift_add_multiplier_pkg::*;
(
  input  logic [OPERAND_W-1:0] a,
  input  logic [OPERAND_W-1:0] b,
  input  logic                 cin,
  output logic [OPERAND_W-1:0] sum,
  output logic                 cout
);

  logic [OPERAND_W:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < OPERAND_W; i++) begin : g_bit
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[OPERAND_W];

endmodule

// File: rtl/four_bit_shift_add_multiplier.sv
// Sequential 4x4 unsigned shift-add multiplier with start/busy/done handshake.
// Optional macro MULT_ZERO_BYPASS_EN: zero operands skip CALC and finish in one cycle.
module four_bit_shift_add_multiplier
  import four_bit_shift_add_multiplier_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [OPERAND_W-1:0] multiplicand,
  input  logic [OPERAND_W-1:0] multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [PRODUCT_W-1:0] product
);

  state_e               state_q, state_d;
  logic [OPERAND_W-1:0] m_q, a_q, q_q;
  logic [COUNT_W-1:0]   count_q;
  logic [PRODUCT_W-1:0] product_q;

  logic [OPERAND_W-1:0] add_b, add_sum;
  logic                 add_cout;

`ifdef MULT_ZERO_BYPASS_EN
  logic zero_op;
  assign zero_op = (multiplicand == '0) || (multiplier == '0);
`endif

  assign add_b = q_q[0] ? m_q : '0;

  four_bit_full_adder_module u_adder (
    .a    (a_q),
    .b    (add_b),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: state_d is defaulted before the case so no path leaves it unassigned
  // (which would infer a latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
`ifdef MULT_ZERO_BYPASS_EN
          state_d = zero_op ? DONE : CALC;
`else
          state_d = CALC;
`endif
        end
      end
      CALC:    if (count_q == LAST_COUNT) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      CALC:    busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // The carry out of each add lands directly in A[3] by the right shift, so the
  // C register is folded into the shift and needs no separate flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_q       <= '0;
      a_q       <= '0;
      q_q       <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            m_q     <= multiplicand;
            q_q     <= multiplier;
            a_q     <= '0;
            count_q <= '0;
`ifdef MULT_ZERO_BYPASS_EN
            if (zero_op) product_q <= '0;
`endif
          end
        end
        CALC: begin
          a_q     <= {add_cout, add_sum[OPERAND_W-1:1]};
          q_q     <= {add_sum[0], q_q[OPERAND_W-1:1]};
          count_q <= count_q + COUNT_W'(1);
          // Capture the final shifted {A,Q} so product is valid during DONE.
          if (count_q == LAST_COUNT)
            product_q <= {add_cout, add_sum, q_q[OPERAND_W-1:1]};
        end
        default: ;
      endcase
    end
  end

  assign product = product_q;

endmodule

// File: tb/tb_four_bit_shift_add_multiplier.sv
// Self-checking bench for four_bit_shift_add_multiplier (scoreboard on done pulses).
module tb_four_bit_shift_add_multiplier;
  import four_bit_shift_add_multiplier_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] multiplicand;
  logic [3:0] multiplier;
  logic       busy;
  logic       done;
  logic [7:0] product;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  four_bit_shift_add_multiplier dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_latency(input logic [3:0] m, input logic [3:0] q);
`ifdef MULT_ZERO_BYPASS_EN
    if (m == 4'd0 || q == 4'd0) return 1;
`endif
    return 5;
  endfunction

  function automatic int exp_busy_cycles(input logic [3:0] m, input logic [3:0] q);
`ifdef MULT_ZERO_BYPASS_EN
    if (m == 4'd0 || q == 4'd0) return 0;
`endif
    return 4;
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) check("done_without_request", 8'(done), 8'd0);
      else                   check("product", product, exp_q.pop_front());
    end
  end

  // Drive a request at a negedge; returns #1 after the accepting edge E0.
  task automatic issue(input logic [3:0] m, input logic [3:0] q,
                       input bit hold, input bit expect_result);
    @(negedge clk);
    multiplicand = m;
    multiplier   = q;
    start        = 1'b1;
    if (expect_result) exp_q.push_back(8'(m) * 8'(q));
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  // Counts negedges after E0; negedge n shows cycle E0+n.
  task automatic await_done(input int exp_lat, input int exp_busy, input string tag);
    int  busy_cnt = 0;
    int  lat      = 0;
    bit  seen     = 1'b0;
    for (int n = 1; n <= 12 && !seen; n++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      check({tag, "_busy_done_overlap"}, 8'(busy & done), 8'd0);
      if (done) begin
        seen = 1'b1;
        lat  = n;
      end
    end
    if (!seen) check({tag, "_timeout"}, 8'(done), 8'd1);
    else       check({tag, "_latency"}, 8'(lat), 8'(exp_lat));
    check({tag, "_busy_cycles"}, 8'(busy_cnt), 8'(exp_busy));
  endtask

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    multiplicand = 4'd0;
    multiplier   = 4'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 8'(busy), 8'd0);
    check("reset_done", 8'(done), 8'd0);
    check("reset_product", product, 8'd0);
    reset = 1'b0;

    // 3 x 5
    issue(4'd3, 4'd5, 1'b0, 1'b1);
    await_done(5, 4, "m3q5");
    @(negedge clk);
    check("product_hold", product, 8'd15);
    check("idle_after_done", 8'(busy | done), 8'd0);

    // 15 x 15 exercises the carry on every iteration
    issue(4'd15, 4'd15, 1'b0, 1'b1);
    await_done(5, 4, "m15q15");

    // zero operand
    issue(4'd0, 4'd9, 1'b0, 1'b1);
    await_done(exp_latency(4'd0, 4'd9), exp_busy_cycles(4'd0, 4'd9), "m0q9");

    // start held high with changing operands: the second request waits for IDLE
    issue(4'd7, 4'd2, 1'b1, 1'b1);
    multiplicand = 4'd9;
    multiplier   = 4'd9;
    await_done(5, 4, "hold_first");
    exp_q.push_back(8'd81);
    @(posedge clk);
    @(posedge clk);
    #1;
    start = 1'b0;
    await_done(5, 4, "hold_second");

    // reset mid-operation aborts with no done pulse
    issue(4'd6, 4'd6, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_state", 8'(dut.state_q), 8'(IDLE));
    check("abort_busy", 8'(busy), 8'd0);
    check("abort_done", 8'(done), 8'd0);
    check("abort_product", product, 8'd0);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("abort_no_done", 8'(done), 8'd0);
    end

    // exhaustive sweep, back-to-back
    for (int m = 0; m < 16; m++) begin
      for (int q = 0; q < 16; q++) begin
        issue(4'(m), 4'(q), 1'b0, 1'b1);
        await_done(exp_latency(4'(m), 4'(q)), exp_busy_cycles(4'(m), 4'(q)), "sweep");
      end
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 8'(exp_q.size()), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
